// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces hsync/vsync, blanking, data-enable, pixel coordinates and line/frame
// strobes for any timing given by parameters. Advances only on cycles with ce=1.
// Optional raster-line interrupt is built when VGA_TIMING_RASTER_IRQ_EN is defined;
// otherwise raster_irq is tied low and irq_line is ignored.
// Line and frame order: active, front porch, sync, back porch.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BP      = 23,
  parameter bit          HSYNC_POS = 1'b1,
  parameter bit          VSYNC_POS = 1'b1,
  parameter int unsigned H_CW      = 11,
  parameter int unsigned V_CW      = 10
) (
  input  logic            clk_pixel,
  input  logic            rst,
  input  logic            ce,
  input  logic [V_CW-1:0] irq_line,
  output logic            hsync,
  output logic            vsync,
  output logic            hblank,
  output logic            vblank,
  output logic            de,
  output logic [H_CW-1:0] h_pos,
  output logic [V_CW-1:0] v_pos,
  output logic            line_start,
  output logic            frame_start,
  output logic            raster_irq
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Back porch is at least one unit, so every boundary below fits the counter width.
  localparam logic [H_CW-1:0] H_LAST     = H_CW'(H_TOTAL - 1);
  localparam logic [H_CW-1:0] H_BLANK_AT = H_CW'(H_ACTIVE);
  localparam logic [H_CW-1:0] HS_START   = H_CW'(H_ACTIVE + H_FP);
  localparam logic [H_CW-1:0] HS_END     = H_CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CW-1:0] V_LAST     = V_CW'(V_TOTAL - 1);
  localparam logic [V_CW-1:0] V_BLANK_AT = V_CW'(V_ACTIVE);
  localparam logic [V_CW-1:0] VS_START   = V_CW'(V_ACTIVE + V_FP);
  localparam logic [V_CW-1:0] VS_END     = V_CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_CW-1:0] h_q, h_d;
  logic [V_CW-1:0] v_q, v_d;
  logic hsync_q, vsync_q, hblank_q, vblank_q, de_q;
  logic line_start_q, frame_start_q, raster_irq_q;
  logic hsync_d, vsync_d, hblank_d, vblank_d, de_d;
  logic line_start_d, frame_start_d, raster_irq_d;
  logic hs_act, vs_act;

  // Next raster position if this edge is ce-qualified.
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  // Decode the next position so registered outputs line up with h_pos/v_pos.
  always_comb begin
    hblank_d     = (h_d >= H_BLANK_AT);
    vblank_d     = (v_d >= V_BLANK_AT);
    de_d         = ~hblank_d & ~vblank_d;
    hs_act       = (h_d >= HS_START) && (h_d < HS_END);
    vs_act       = (v_d >= VS_START) && (v_d < VS_END);
    hsync_d      = HSYNC_POS ? hs_act : ~hs_act;
    vsync_d      = VSYNC_POS ? vs_act : ~vs_act;
    line_start_d = (h_d == '0);
    frame_start_d = line_start_d && (v_d == '0);
`ifdef VGA_TIMING_RASTER_IRQ_EN
    // v_d never reaches V_TOTAL, so an out-of-range irq_line simply never matches.
    raster_irq_d = line_start_d && (v_d == irq_line);
`else
    raster_irq_d = 1'b0;
`endif
  end

`ifndef VGA_TIMING_RASTER_IRQ_EN
  logic irq_line_unused;
  assign irq_line_unused = ^irq_line;
`endif

  // Counter and output registers; reset parks on the last back-porch pixel.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      de_q          <= 1'b0;
      hsync_q       <= ~HSYNC_POS;
      vsync_q       <= ~VSYNC_POS;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      raster_irq_q  <= 1'b0;
    end else if (ce) begin
      h_q           <= h_d;
      v_q           <= v_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      raster_irq_q  <= raster_irq_d;
    end else begin
      // Levels hold; strobes must not stretch across stalled cycles.
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      raster_irq_q  <= 1'b0;
    end
  end

  assign h_pos       = h_q;
  assign v_pos       = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign raster_irq  = raster_irq_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed-mode vga_sync raster generator. Produces hsync, vsync, blanking, data-enable, pixel coordinates and line/frame strobes for any timing given by parameters.
- Adds selectable sync polarity, a pixel clock-enable for running from a faster system clock, and an optional raster-line interrupt.
- Sits between the pixel clock domain and the framebuffer fetch / pixel output stages.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync width (pixels)
- H_BP, 88, horizontal back porch (pixels); must be >=1
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines); must be >=1
- HSYNC_POS, 1, 1 = hsync active-high, 0 = active-low
- VSYNC_POS, 1, 1 = vsync active-high, 0 = active-low
- H_CW, 11, width of h_pos; must satisfy 2^H_CW >= H_TOTAL
- V_CW, 10, width of v_pos; must satisfy 2^V_CW >= V_TOTAL

Ports:
- clk_pixel  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- ce  in  1  pixel advance enable; tie 1 for one pixel per clock
- hsync  out  1  horizontal sync, polarity per HSYNC_POS
- vsync  out  1  vertical sync, polarity per VSYNC_POS
- hblank  out  1  high when h_pos >= H_ACTIVE
- vblank  out  1  high when v_pos >= V_ACTIVE
- de  out  1  ~hblank & ~vblank
- h_pos  out  H_CW  current pixel column
- v_pos  out  V_CW  current line
- line_start  out  1  one-clk strobe on entry to h_pos==0
- frame_start  out  1  one-clk strobe on entry to (0,0)
- irq_line  in  V_CW  raster interrupt line (feature only)
- raster_irq  out  1  raster interrupt strobe (feature only)

Behaviour:
- Definitions: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056). V_TOTAL likewise (default 628).
- Line order: active, front porch, sync, back porch. Frame order is the same in lines.
- Sync windows:
  - hsync active for H_ACTIVE+H_FP <= h_pos < H_ACTIVE+H_FP+H_SYNC.
  - vsync active for V_ACTIVE+V_FP <= v_pos < V_ACTIVE+V_FP+V_SYNC, for the entire line including hblank.
- Registered outputs: all outputs are registered and mutually aligned. In any cycle, hsync/vsync/hblank/vblank/de describe exactly the (h_pos, v_pos) presented in that cycle. No combinational path from ce to outputs.
- Advance: on a rising edge with rst=0 and ce=1, h_pos increments.
  - At h_pos==H_TOTAL-1, h_pos wraps to 0 and v_pos increments.
  - At v_pos==V_TOTAL-1 with h_pos wrapping, v_pos wraps to 0.
- ce=0: all counters and level outputs hold. Strobes go to 0 on that edge.
- Strobes:
  - line_start=1 for exactly one clk_pixel cycle, following the ce-qualified edge that enters h_pos==0.
  - frame_start=1 likewise on entry to (0,0); it coincides with that line_start.
  - Strobes never stretch while ce is low.
- Reset:
  - While rst=1 (sampled each edge), h_pos=H_TOTAL-1 and v_pos=V_TOTAL-1, i.e. the last back-porch pixel.
  - Outputs in reset: hblank=1, vblank=1, de=0, hsync=~HSYNC_POS, vsync=~VSYNC_POS, line_start=0, frame_start=0, raster_irq=0.
  - First ce-qualified edge after release: (0,0), de=1, line_start=1, frame_start=1.
- Reset mid-frame: the next edge forces the reset state regardless of ce. Reset takes priority over ce.
- Arithmetic: compares use full counter width. The counter never exceeds TOTAL-1. No saturation or overflow path.

Optional Feature:
- Macro: VGA_TIMING_RASTER_IRQ_EN
- With macro:
  - irq_line is sampled on each ce-qualified edge that enters h_pos==0.
  - If the new v_pos equals the sampled value, raster_irq=1 for one cycle, aligned with line_start.
  - irq_line >= V_TOTAL never fires.
- Without macro: irq_line is ignored and raster_irq is constant 0. Ports remain present.

Test Plan:
- Defaults, ce=1, release reset: first edge gives h_pos=0, v_pos=0, de=1, frame_start=1. Next frame_start occurs exactly 663168 cycles later. line_start period is 1056 cycles.
- Default line: hblank rises at h_pos=800. hsync is high for h_pos 840..967, exactly 128 cycles. vsync is high for v_pos 601..604, exactly 4*1056 cycles.
- HSYNC_POS=0, VSYNC_POS=0, small mode (H 8/2/2/2, V 4/1/1/1): syncs idle high and pulse low. Checker compares every cycle against a reference model over 3 frames.
- ce toggling 1-0-0-1 at h_pos=1055: counters hold during the low cycles. line_start pulses once only, one cycle after the enabling edge. The frame period measured in ce-high edges is unchanged.
- Assert rst at h_pos=300, v_pos=200 for 2 cycles: outputs match the reset values on the next edge. Resume at (0,0) with frame_start=1.
- VGA_TIMING_RASTER_IRQ_EN, irq_line=599: raster_irq is 1 exactly once per frame, coincident with line_start at v_pos=599.
  - irq_line=700: never fires.
  - Macro undefined: raster_irq stays 0.
